// File: rtl/shiftreg_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
package shiftreg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_LOAD  = 3'd5;
  localparam logic [2:0] MODE_CLEAR = 3'd6;

  // Bits needed to hold a fill count in the range 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftreg_fill_cnt.sv
// Saturating fill counter: counts serially shifted-in bits up to MAX.
module shiftreg_fill_cnt
  import shiftreg_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inc,
  input  logic                    i_set,
  input  logic                    i_clr,
  output logic [cnt_w(MAX)-1:0]   o_count,
  output logic                    o_full
);

  localparam int             CW    = cnt_w(MAX);
  localparam logic [CW-1:0]  MAX_C = CW'(MAX);

  logic [CW-1:0] r_count;

  // Clear wins over set, set over increment; increment stops at MAX.
  always_ff @(posedge i_clk) begin
    if (i_rst)                            r_count <= '0;
    else if (i_clr)                       r_count <= '0;
    else if (i_set)                       r_count <= MAX_C;
    else if (i_inc && (r_count != MAX_C)) r_count <= r_count + CW'(1);
  end

  assign o_count = r_count;
  assign o_full  = (r_count == MAX_C);

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register: shift/rotate/load/clear with serial-out and fill count.
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [2:0]                i_mode,
  input  logic                      i_input,
  input  logic [WIDTH-1:0]          i_load_data,
  output logic [WIDTH-1:0]          o_out,
  output logic                      o_sout,
  output logic [cnt_w(WIDTH)-1:0]   o_count,
  output logic                      o_full
);

  logic [WIDTH-1:0] r_out;
  logic             r_sout;
  logic             w_inc;
  logic             w_set;
  logic             w_clr;

  // Fill-counter controls decoded from the active mode.
  always_comb begin
    w_inc = 1'b0;
    w_set = 1'b0;
    w_clr = 1'b0;
    if (i_en) begin
      case (i_mode)
        MODE_SHL, MODE_SHR: w_inc = 1'b1;
        MODE_LOAD:          w_set = 1'b1;
        MODE_CLEAR:         w_clr = 1'b1;
        default:            ;
      endcase
    end
  end

  // Data path and serial-out; i_input is only looked at in the shift modes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out  <= RESET_VAL;
      r_sout <= 1'b0;
    end else if (i_en) begin
      case (i_mode)
        MODE_SHL: begin
          r_out  <= {r_out[WIDTH-2:0], i_input};
          r_sout <= r_out[WIDTH-1];
        end
        MODE_SHR: begin
          r_out  <= {i_input, r_out[WIDTH-1:1]};
          r_sout <= r_out[0];
        end
        MODE_ROL: begin
          r_out  <= {r_out[WIDTH-2:0], r_out[WIDTH-1]};
          r_sout <= r_out[WIDTH-1];
        end
        MODE_ROR: begin
          r_out  <= {r_out[0], r_out[WIDTH-1:1]};
          r_sout <= r_out[0];
        end
        MODE_LOAD: r_out <= i_load_data;
        MODE_CLEAR: begin
          r_out  <= '0;
          r_sout <= 1'b0;
        end
        default: ;  // HOLD and reserved encoding
      endcase
    end
  end

  shiftreg_fill_cnt #(.MAX(WIDTH)) u_fill_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_inc),
    .i_set   (w_set),
    .i_clr   (w_clr),
    .o_count (o_count),
    .o_full  (o_full)
  );

  assign o_out  = r_out;
  assign o_sout = r_sout;

endmodule

// File: tb/tb_shiftreg_univ.sv
// Self-checking bench: three widths (8, 2, 16) driven in lockstep against a reference model.
module tb_shiftreg_univ;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR  = 3'd4, LOAD = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst, en, sin;
  logic [2:0]  mode;
  logic [15:0] ld;

  logic [7:0]  out8;  logic sout8;  logic [3:0] cnt8;  logic full8;
  logic [1:0]  out2;  logic sout2;  logic [1:0] cnt2;  logic full2;
  logic [15:0] out16; logic sout16; logic [4:0] cnt16; logic full16;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: index 0 -> WIDTH 8, 1 -> WIDTH 2, 2 -> WIDTH 16.
  int          ws[3] = '{8, 2, 16};
  logic [15:0] m_out[3];
  logic        m_sout[3];
  int          m_cnt[3];

  always #5 clk = ~clk;

  shiftreg_univ #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_input(sin),
    .i_load_data(ld[7:0]), .o_out(out8), .o_sout(sout8), .o_count(cnt8), .o_full(full8));

  shiftreg_univ #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_input(sin),
    .i_load_data(ld[1:0]), .o_out(out2), .o_sout(sout2), .o_count(cnt2), .o_full(full2));

  shiftreg_univ #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_input(sin),
    .i_load_data(ld), .o_out(out16), .o_sout(sout16), .o_count(cnt16), .o_full(full16));

  // Apply one cycle of stimulus to all instances and advance the model by the same rules.
  task automatic tick(input logic r, input logic e, input logic [2:0] m,
                      input logic s, input logic [15:0] d);
    logic [15:0] mask;
    int          w;
    rst = r; en = e; mode = m; sin = s; ld = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      w    = ws[k];
      mask = 16'((32'd1 << w) - 1);
      if (r) begin
        m_out[k] = '0; m_sout[k] = 1'b0; m_cnt[k] = 0;
      end else if (e) begin
        case (m)
          SHL: begin
            m_sout[k] = m_out[k][w-1];
            m_out[k]  = ((m_out[k] << 1) | 16'(s)) & mask;
            m_cnt[k]  = (m_cnt[k] + 1 > w) ? w : m_cnt[k] + 1;
          end
          SHR: begin
            m_sout[k] = m_out[k][0];
            m_out[k]  = (m_out[k] >> 1) | (16'(s) << (w - 1));
            m_cnt[k]  = (m_cnt[k] + 1 > w) ? w : m_cnt[k] + 1;
          end
          ROL: begin
            m_sout[k] = m_out[k][w-1];
            m_out[k]  = ((m_out[k] << 1) | (m_out[k] >> (w - 1))) & mask;
          end
          ROR: begin
            m_sout[k] = m_out[k][0];
            m_out[k]  = (m_out[k] >> 1) | ((m_out[k] & 16'd1) << (w - 1));
          end
          LOAD: begin
            m_out[k] = d & mask;
            m_cnt[k] = w;
          end
          CLR: begin
            m_out[k] = '0; m_sout[k] = 1'b0; m_cnt[k] = 0;
          end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, SHL, 1, 16'h0);
    tick(1, 1, SHL, 1, 16'h0);
    n_chk++; if (out8 !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", out8); end
    n_chk++; if (sout8 !== 1'b0) begin n_fail++; $display("FAIL reset_sout got=%b exp=0", sout8); end
    n_chk++; if (cnt8 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    n_chk++; if (full8 !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full8); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, SHL, 1, 16'h0);
      n_chk++; if (out8 !== 8'h00) begin n_fail++; $display("FAIL en_hold_out cyc=%0d got=%h exp=00", i, out8); end
      n_chk++; if (cnt8 !== 4'd0) begin n_fail++; $display("FAIL en_hold_cnt cyc=%0d got=%0d exp=0", i, cnt8); end
    end
  endtask

  task automatic test_serial_fill();
    logic [7:0] bits;
    bits = 8'b1011_0010;  // fed MSB first
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, SHL, bits[7-i], 16'h0);
      n_chk++; if (cnt8 !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_cnt i=%0d got=%0d exp=%0d", i, cnt8, i + 1); end
      n_chk++; if (full8 !== (i == 7)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full8, i == 7); end
    end
    n_chk++; if (out8 !== 8'hB2) begin n_fail++; $display("FAIL fill_out got=%h exp=b2", out8); end
    tick(0, 1, SHL, 1, 16'h0);
    n_chk++; if (out8 !== 8'h65) begin n_fail++; $display("FAIL sat_out got=%h exp=65", out8); end
    n_chk++; if (sout8 !== 1'b1) begin n_fail++; $display("FAIL sat_sout got=%b exp=1", sout8); end
    n_chk++; if (cnt8 !== 4'd8) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=8", cnt8); end
  endtask

  task automatic test_load_rotate();
    logic [7:0] exp_o[4];
    exp_o = '{8'h81, 8'h03, 8'h81, 8'hC0};
    tick(0, 1, LOAD, 0, 16'h0081);
    n_chk++; if (out8 !== exp_o[0]) begin n_fail++; $display("FAIL load_out got=%h exp=%h", out8, exp_o[0]); end
    n_chk++; if (cnt8 !== 4'd8) begin n_fail++; $display("FAIL load_cnt got=%0d exp=8", cnt8); end
    tick(0, 1, ROL, 0, 16'h0);
    n_chk++; if (out8 !== exp_o[1] || sout8 !== 1'b1) begin n_fail++; $display("FAIL rol got=%h/%b exp=%h/1", out8, sout8, exp_o[1]); end
    for (int i = 2; i < 4; i++) begin
      tick(0, 1, ROR, 0, 16'h0);
      n_chk++; if (out8 !== exp_o[i] || sout8 !== 1'b1) begin n_fail++; $display("FAIL ror%0d got=%h/%b exp=%h/1", i - 1, out8, sout8, exp_o[i]); end
      n_chk++; if (cnt8 !== 4'd8) begin n_fail++; $display("FAIL rot_cnt got=%0d exp=8", cnt8); end
    end
  endtask

  task automatic test_shr();
    logic [3:0] exp_s;
    exp_s = 4'b0101;  // bit i is the i-th serial-out
    tick(0, 1, LOAD, 0, 16'h00A5);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, SHR, 0, 16'h0);
      n_chk++; if (sout8 !== exp_s[i]) begin n_fail++; $display("FAIL shr_sout i=%0d got=%b exp=%b", i, sout8, exp_s[i]); end
    end
    n_chk++; if (out8 !== 8'h0A) begin n_fail++; $display("FAIL shr_out got=%h exp=0a", out8); end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 5; i++) tick(0, 1, SHL, 1'($urandom), 16'h0);
    tick(0, 1, CLR, 1, 16'h0);
    n_chk++; if (out8 !== 8'h00 || cnt8 !== 4'd0 || sout8 !== 1'b0) begin n_fail++; $display("FAIL clear got=%h/%0d/%b exp=00/0/0", out8, cnt8, sout8); end
    for (int i = 0; i < 3; i++) tick(0, 1, SHL, 1, 16'h0);
    tick(1, 1, LOAD, 0, 16'hFFFF);
    n_chk++; if (out8 !== 8'h00 || cnt8 !== 4'd0) begin n_fail++; $display("FAIL rst_over_load got=%h/%0d exp=00/0", out8, cnt8); end
    tick(0, 1, SHR, 1, 16'h0);
    n_chk++; if (cnt8 !== 4'd1 || out8 !== 8'h80) begin n_fail++; $display("FAIL first_after_rst got=%h/%0d exp=80/1", out8, cnt8); end
  endtask

  task automatic test_reserved();
    tick(0, 1, LOAD, 0, 16'h003C);
    tick(0, 1, RSV, 1, 16'h0);
    n_chk++; if (out8 !== 8'h3C || cnt8 !== 4'd8) begin n_fail++; $display("FAIL mode7 got=%h/%0d exp=3c/8", out8, cnt8); end
    tick(0, 1, HOLD, 1'bx, 16'h0);
    tick(0, 1, ROL, 1'bx, 16'h0);
    tick(0, 1, LOAD, 1'bx, 16'h005A);
    n_chk++; if ($isunknown({out8, sout8, cnt8}) || out8 !== 8'h5A) begin n_fail++; $display("FAIL x_input got=%h/%b/%0d exp=5a no X", out8, sout8, cnt8); end
  endtask

  task automatic test_widths();
    tick(1, 1, HOLD, 0, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 1, ($urandom_range(0, 1) != 0) ? SHL : SHR, 1'($urandom), 16'h0);
      n_chk++; if (full2 !== (i >= 2) || full8 !== (i >= 8) || full16 !== (i >= 16)) begin
        n_fail++; $display("FAIL width_full n=%0d got=%b%b%b", i, full2, full8, full16);
      end
      n_chk++; if (out2 !== m_out[1][1:0] || out16 !== m_out[2] || cnt16 !== 5'(m_cnt[2])) begin
        n_fail++; $display("FAIL width_data n=%0d got=%h/%h/%0d exp=%h/%h/%0d", i, out2, out16, cnt16, m_out[1][1:0], m_out[2], m_cnt[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), 3'($urandom),
           1'($urandom), 16'($urandom));
      n_chk++; if (out8 !== m_out[0][7:0] || sout8 !== m_sout[0] || cnt8 !== 4'(m_cnt[0]) || full8 !== (m_cnt[0] == 8)) begin
        n_fail++; $display("FAIL rand_w8 i=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, out8, sout8, cnt8, m_out[0][7:0], m_sout[0], m_cnt[0]);
      end
      n_chk++; if (out2 !== m_out[1][1:0] || sout2 !== m_sout[1] || cnt2 !== 2'(m_cnt[1]) || full2 !== (m_cnt[1] == 2)) begin
        n_fail++; $display("FAIL rand_w2 i=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, out2, sout2, cnt2, m_out[1][1:0], m_sout[1], m_cnt[1]);
      end
      n_chk++; if (out16 !== m_out[2] || sout16 !== m_sout[2] || cnt16 !== 5'(m_cnt[2]) || full16 !== (m_cnt[2] == 16)) begin
        n_fail++; $display("FAIL rand_w16 i=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, out16, sout16, cnt16, m_out[2], m_sout[2], m_cnt[2]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_out[k] = '0; m_sout[k] = 1'b0; m_cnt[k] = 0; end
    rst = 1'b1; en = 1'b0; mode = HOLD; sin = 1'b0; ld = '0;
    test_reset();
    test_serial_fill();
    test_load_rotate();
    test_shr();
    test_clear_reset();
    test_reserved();
    test_widths();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftreg_univ.md
Name: shiftreg_univ

Overview:
Parametrised universal shift register. It succeeds the fixed 8-bit serial-in shift register and adds configurable width, a mode select (shift left/right, rotate, parallel load, clear, hold), clock enable, registered serial-out and a saturating fill counter. It serves as the common serialiser/deserialiser building block for later chapters, for example UART and SPI datapaths.

Parameters:
WIDTH, 8, register width in bits; must be >= 2
RESET_VAL, {WIDTH{1'b0}}, value loaded into o_out on reset

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_en  input  1  clock enable; 0 = hold all state regardless of i_mode
i_mode  input  3  operation select (encoding below)
i_input  input  1  serial data in
i_load_data  input  WIDTH  parallel load value
o_out  output  WIDTH  register contents
o_sout  output  1  registered serial out: bit most recently shifted out
o_count  output  $clog2(WIDTH+1)  number of valid serially-filled bits, saturating
o_full  output  1  high when o_count == WIDTH

Behaviour:
- Reset has priority over everything, including i_en=0, at the rising edge with i_rst=1:
  - o_out <= RESET_VAL
  - o_sout <= 0
  - o_count <= 0
  - o_full therefore reads 0
- When i_en=0 and no reset: all registers hold.
- When i_en=1, the i_mode encoding is:
  - 0 HOLD: no change to any register.
  - 1 SHL: o_out <= {o_out[WIDTH-2:0], i_input}; o_sout <= old o_out[WIDTH-1]; o_count <= min(o_count+1, WIDTH).
  - 2 SHR: o_out <= {i_input, o_out[WIDTH-1:1]}; o_sout <= old o_out[0]; o_count <= min(o_count+1, WIDTH).
  - 3 ROL: o_out <= {o_out[WIDTH-2:0], o_out[WIDTH-1]}; o_sout <= old o_out[WIDTH-1]; o_count unchanged.
  - 4 ROR: o_out <= {o_out[0], o_out[WIDTH-1:1]}; o_sout <= old o_out[0]; o_count unchanged.
  - 5 LOAD: o_out <= i_load_data; o_sout unchanged; o_count <= WIDTH, since the register is fully defined.
  - 6 CLEAR: o_out <= 0; o_sout <= 0; o_count <= 0.
  - 7 reserved: behaves as HOLD.
- Latency: one cycle. The updated o_out, o_sout and o_count are visible after the same rising edge that samples the inputs.
- o_full is combinational from o_count; no extra latency.
- Saturation: once o_count == WIDTH, further SHL/SHR keep shifting data but o_count stays at WIDTH. It never wraps.
- Switching between SHL and SHR mid-fill: the count continues to accumulate, with no reset on direction change.
- Reset mid-fill discards contents and count. The first shift after reset deasserts gives o_count=1.
- i_input is sampled only in SHL/SHR. X on i_input in other modes must not propagate into state.
- No combinational path from any input to o_out, o_sout or o_count.

Decomposition:
- Package shiftreg_pkg:
  - 3-bit mode localparams MODE_HOLD=0, MODE_SHL=1, MODE_SHR=2, MODE_ROL=3, MODE_ROR=4, MODE_LOAD=5, MODE_CLEAR=6
  - function for count width, clog2(WIDTH+1)
- One sub-module, shiftreg_fill_cnt:
  - saturating up-counter with inc, set-to-max and clear inputs, parameterised by MAX=WIDTH
  - drives o_count and o_full
- The data path stays in the top module as a single case statement on i_mode.

Test Plan:
- Reset and enable: hold i_rst=1 for 2 cycles with i_en=1 and i_mode=SHL -> o_out=8'h00, o_sout=0, o_count=0, o_full=0. Release reset, drive i_en=0, i_mode=SHL, i_input=1 for 3 cycles -> o_out stays 8'h00, o_count stays 0.
- Serial fill, WIDTH=8: SHL feeding bits 1,0,1,1,0,0,1,0 (first bit first) over 8 cycles -> o_out=8'hB2, o_count steps 1..8, o_full rises on the 8th edge. A 9th SHL with i_input=1 -> o_out=8'h65, o_sout=1, o_count stays 8.
- Load and rotate: LOAD i_load_data=8'h81 -> o_out=8'h81, o_count=8. ROL -> 8'h03, o_sout=1. ROR twice -> 8'h81 then 8'hC0, o_sout=1 then 1. o_count stays 8 throughout.
- Shift right: after LOAD 8'hA5, do SHR with i_input=0 four times -> o_out=8'h0A; o_sout sequence is 1,0,1,0.
- CLEAR and mid-operation reset: fill 5 bits with SHL, then CLEAR -> o_out=0, o_count=0. Fill 3 bits, assert i_rst for 1 cycle while i_mode=LOAD -> o_out=RESET_VAL and o_count=0; the load is ignored.
- Mode 7 and reserved behaviour: from o_out=8'h3C, o_count=8, apply i_mode=7 with i_en=1 and i_input=1 -> all outputs unchanged. Run the same sequences at WIDTH=2 and WIDTH=16; o_full asserts after exactly WIDTH shifts.
